// File: rtl/dm_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
// Owner encoding is used for grant winner, last owner and read-return owner.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_HOST
    } owner_t;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// One requester's view of the data-memory port.
// The master drives the request and the slave answers with the grant and read return.
interface dm_port_if #(
    parameter int AW = 8,
    parameter int DW = 8
);

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/dm_port_arbiter.sv
// Shares the byte-wide dm port between the core LSU and the host port.
// Round-robin on conflict, host lock-out, 1-cycle read return, saturating conflict counter.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    dm_port_if.slave      core,
    dm_port_if.slave      host,
    input  logic          host_lock,
    output logic          core_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [CW-1:0] conflict_cnt
);

    owner_t last_owner;
    owner_t rd_owner;
    owner_t win;
    owner_t rd_next;
    logic   core_ok;
    logic   host_ok;
    logic   both_req;

    // Grants are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        core_ok = reset & core.req & ~host_lock;
        host_ok = reset & host.req;
        win     = OWN_NONE;
        unique case (1'b1)
            core_ok && host_ok:
                win = (last_owner == OWN_CORE) ? OWN_HOST : OWN_CORE;
            core_ok && !host_ok:
                win = OWN_CORE;
            !core_ok && host_ok:
                win = OWN_HOST;
            default:
                win = OWN_NONE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (win)
            OWN_CORE: begin
                mem_en    = 1'b1;
                mem_we    = core.we;
                mem_addr  = core.addr;
                mem_wdata = core.wdata;
            end
            OWN_HOST: begin
                mem_en    = 1'b1;
                mem_we    = host.we;
                mem_addr  = host.addr;
                mem_wdata = host.wdata;
            end
            default: begin
                mem_en    = 1'b0;
            end
        endcase
    end

    always_comb begin
        core.gnt    = (win == OWN_CORE);
        host.gnt    = (win == OWN_HOST);
        core_stall  = reset & core.req & (win != OWN_CORE);
        rd_next     = (mem_en && !mem_we) ? win : OWN_NONE;
        both_req    = core.req & host.req;
        core.rvalid = (rd_owner == OWN_CORE);
        host.rvalid = (rd_owner == OWN_HOST);
        core.rdata  = core.rvalid ? mem_rdata : '0;
        host.rdata  = host.rvalid ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner   <= OWN_HOST;
            rd_owner     <= OWN_NONE;
            conflict_cnt <= '0;
        end else begin
            if (win != OWN_NONE)
                last_owner <= win;
            rd_owner <= rd_next;
            if (both_req && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a 256 x 8 synchronous dm model.
// A second CW=4 instance shares the stimulus to exercise counter saturation.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_init;
    logic        host_lock;
    logic        core_stall;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [15:0] cnt;
    logic        stall4, en4, we4;
    logic [7:0]  addr4, wd4;
    logic [3:0]  cnt4;
    logic [7:0]  mem [256];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    dm_port_if cif ();
    dm_port_if hif ();
    dm_port_if cif4 ();
    dm_port_if hif4 ();

    assign cif4.req   = cif.req;
    assign cif4.we    = cif.we;
    assign cif4.addr  = cif.addr;
    assign cif4.wdata = cif.wdata;
    assign hif4.req   = hif.req;
    assign hif4.we    = hif.we;
    assign hif4.addr  = hif.addr;
    assign hif4.wdata = hif.wdata;

    dm_port_arbiter u_dut (
        .clk          (clk),
        .reset        (reset),
        .core         (cif),
        .host         (hif),
        .host_lock    (host_lock),
        .core_stall   (core_stall),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (cnt)
    );

    dm_port_arbiter #(.CW(4)) u_sat (
        .clk          (clk),
        .reset        (reset),
        .core         (cif4),
        .host         (hif4),
        .host_lock    (host_lock),
        .core_stall   (stall4),
        .mem_en       (en4),
        .mem_we       (we4),
        .mem_addr     (addr4),
        .mem_wdata    (wd4),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (cnt4)
    );

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= 8'h00;
            mem[66]   <= 8'h11;
            mem[68]   <= 8'h22;
            mem_rdata <= 8'h00;
        end else if (mem_en) begin
            if (mem_we)
                mem[mem_addr] <= mem_wdata;
            else
                mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        logic       cr, cw;
        logic [7:0] ca, cd;
        logic       hr, hw;
        logic [7:0] ha, hd;
        logic       lk;
        logic       cg, hg, st, cv;
        logic [7:0] crd;
        logic       hv;
        logic [7:0] hrd;
        logic       me, mw;
        logic [7:0] ma, md;
        logic [15:0] cn;
    } vec_t;

    vec_t vec [14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        cif.req = 1'b0; cif.we = 1'b0; cif.addr = 8'd0; cif.wdata = 8'd0;
        hif.req = 1'b0; hif.we = 1'b0; hif.addr = 8'd0; hif.wdata = 8'd0;
        host_lock = 1'b0;
    endtask

    task automatic both_read();
        idle_in();
        cif.req = 1'b1; cif.addr = 8'd66;
        hif.req = 1'b1; hif.addr = 8'd68;
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_core_gnt"}, 32'(cif.gnt), 0);
        chk({p, "_host_gnt"}, 32'(hif.gnt), 0);
        chk({p, "_stall"}, 32'(core_stall), 0);
        chk({p, "_core_rvalid"}, 32'(cif.rvalid), 0);
        chk({p, "_host_rvalid"}, 32'(hif.rvalid), 0);
        chk({p, "_core_rdata"}, 32'(cif.rdata), 0);
        chk({p, "_host_rdata"}, 32'(hif.rdata), 0);
        chk({p, "_mem_en"}, 32'(mem_en), 0);
        chk({p, "_mem_we"}, 32'(mem_we), 0);
        chk({p, "_mem_addr"}, 32'(mem_addr), 0);
        chk({p, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({p, "_cnt"}, 32'(cnt), 0);
        chk({p, "_cnt4"}, 32'(cnt4), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        vec[0]  = '{1'b1,1'b0,8'd66,8'h00, 1'b0,1'b0,8'd0,8'h00,  1'b0, 1'b1,1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b1,1'b0,8'd66,8'h00, 16'd0};
        vec[1]  = '{1'b1,1'b0,8'd66,8'h00, 1'b1,1'b0,8'd68,8'h00, 1'b0, 1'b0,1'b1,1'b1, 1'b1,8'h11, 1'b0,8'h00, 1'b1,1'b0,8'd68,8'h00, 16'd0};
        vec[2]  = '{1'b1,1'b0,8'd66,8'h00, 1'b1,1'b0,8'd68,8'h00, 1'b0, 1'b1,1'b0,1'b0, 1'b0,8'h00, 1'b1,8'h22, 1'b1,1'b0,8'd66,8'h00, 16'd1};
        vec[3]  = '{1'b1,1'b0,8'd66,8'h00, 1'b1,1'b0,8'd68,8'h00, 1'b0, 1'b0,1'b1,1'b1, 1'b1,8'h11, 1'b0,8'h00, 1'b1,1'b0,8'd68,8'h00, 16'd2};
        vec[4]  = '{1'b0,1'b0,8'd0,8'h00,  1'b0,1'b0,8'd0,8'h00,  1'b0, 1'b0,1'b0,1'b0, 1'b0,8'h00, 1'b1,8'h22, 1'b0,1'b0,8'd0,8'h00,  16'd3};
        vec[5]  = '{1'b1,1'b0,8'd66,8'h00, 1'b1,1'b0,8'd68,8'h00, 1'b0, 1'b1,1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b1,1'b0,8'd66,8'h00, 16'd3};
        vec[6]  = '{1'b1,1'b1,8'd67,8'h12, 1'b0,1'b0,8'd0,8'h00,  1'b0, 1'b1,1'b0,1'b0, 1'b1,8'h11, 1'b0,8'h00, 1'b1,1'b1,8'd67,8'h12, 16'd4};
        vec[7]  = '{1'b0,1'b0,8'd0,8'h00,  1'b1,1'b0,8'd67,8'h00, 1'b0, 1'b0,1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b1,1'b0,8'd67,8'h00, 16'd4};
        vec[8]  = '{1'b0,1'b0,8'd0,8'h00,  1'b0,1'b0,8'd0,8'h00,  1'b0, 1'b0,1'b0,1'b0, 1'b0,8'h00, 1'b1,8'h12, 1'b0,1'b0,8'd0,8'h00,  16'd4};
        vec[9]  = '{1'b0,1'b0,8'd0,8'h00,  1'b0,1'b0,8'd0,8'h00,  1'b0, 1'b0,1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b0,1'b0,8'd0,8'h00,  16'd4};
        vec[10] = '{1'b1,1'b0,8'd66,8'h00, 1'b1,1'b0,8'd68,8'h00, 1'b1, 1'b0,1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1,1'b0,8'd68,8'h00, 16'd4};
        vec[11] = '{1'b1,1'b0,8'd66,8'h00, 1'b0,1'b0,8'd0,8'h00,  1'b1, 1'b0,1'b0,1'b1, 1'b0,8'h00, 1'b1,8'h22, 1'b0,1'b0,8'd0,8'h00,  16'd5};
        vec[12] = '{1'b1,1'b0,8'd66,8'h00, 1'b0,1'b0,8'd0,8'h00,  1'b0, 1'b1,1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b1,1'b0,8'd66,8'h00, 16'd5};
        vec[13] = '{1'b0,1'b0,8'd0,8'h00,  1'b0,1'b0,8'd0,8'h00,  1'b0, 1'b0,1'b0,1'b0, 1'b1,8'h11, 1'b0,8'h00, 1'b0,1'b0,8'd0,8'h00,  16'd5};

        reset    = 1'b0;
        mem_init = 1'b1;
        idle_in();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        mem_init = 1'b0;
        reset    = 1'b1;

        // Table: round-robin, idle hold, write-then-read, lock-out
        @(posedge clk); #1;
        for (int v = 0; v < 14; v++) begin
            cif.req = vec[v].cr; cif.we = vec[v].cw;
            cif.addr = vec[v].ca; cif.wdata = vec[v].cd;
            hif.req = vec[v].hr; hif.we = vec[v].hw;
            hif.addr = vec[v].ha; hif.wdata = vec[v].hd;
            host_lock = vec[v].lk;
            @(negedge clk);
            chk($sformatf("v%0d_core_gnt", v), 32'(cif.gnt), 32'(vec[v].cg));
            chk($sformatf("v%0d_host_gnt", v), 32'(hif.gnt), 32'(vec[v].hg));
            chk($sformatf("v%0d_stall", v), 32'(core_stall), 32'(vec[v].st));
            chk($sformatf("v%0d_core_rvalid", v), 32'(cif.rvalid), 32'(vec[v].cv));
            chk($sformatf("v%0d_core_rdata", v), 32'(cif.rdata), 32'(vec[v].crd));
            chk($sformatf("v%0d_host_rvalid", v), 32'(hif.rvalid), 32'(vec[v].hv));
            chk($sformatf("v%0d_host_rdata", v), 32'(hif.rdata), 32'(vec[v].hrd));
            chk($sformatf("v%0d_mem_en", v), 32'(mem_en), 32'(vec[v].me));
            chk($sformatf("v%0d_mem_we", v), 32'(mem_we), 32'(vec[v].mw));
            chk($sformatf("v%0d_mem_addr", v), 32'(mem_addr), 32'(vec[v].ma));
            chk($sformatf("v%0d_mem_wdata", v), 32'(mem_wdata), 32'(vec[v].md));
            chk($sformatf("v%0d_cnt", v), 32'(cnt), 32'(vec[v].cn));
            @(posedge clk); #1;
        end

        // Reset asserted while a host read return is pending
        idle_in();
        hif.req = 1'b1; hif.addr = 8'd66;
        @(negedge clk);
        chk("t1_host_gnt", 32'(hif.gnt), 1);
        #1 reset = 1'b0;
        #1 chk_zero("t1_in_reset");
        @(posedge clk); #1;
        chk("t1_host_rvalid", 32'(hif.rvalid), 0);
        chk("t1_host_rdata", 32'(hif.rdata), 0);
        idle_in();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_post_host_rvalid", 32'(hif.rvalid), 0);
        chk("t1_post_cnt", 32'(cnt), 0);

        // Continuous conflict: core wins first, then strict alternation
        @(posedge clk); #1;
        both_read();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("t3_core_gnt%0d", i), 32'(cif.gnt), 32'(i % 2 == 0));
            chk($sformatf("t3_host_gnt%0d", i), 32'(hif.gnt), 32'(i % 2 == 1));
            chk($sformatf("t3_core_rv%0d", i), 32'(cif.rvalid), 32'(i % 2 == 1));
            chk($sformatf("t3_host_rv%0d", i), 32'(hif.rvalid),
                32'(i > 0 && i % 2 == 0));
            chk($sformatf("t3_core_rd%0d", i), 32'(cif.rdata),
                (i % 2 == 1) ? 32'h11 : 32'h0);
            chk($sformatf("t3_host_rd%0d", i), 32'(hif.rdata),
                (i > 0 && i % 2 == 0) ? 32'h22 : 32'h0);
            chk($sformatf("t3_cnt%0d", i), 32'(cnt), 32'(i));
            @(posedge clk); #1;
        end

        // Locked host preload of 0..63 while the core keeps requesting
        idle_in();
        host_lock = 1'b1;
        cif.req = 1'b1; cif.addr = 8'd66;
        hif.req = 1'b1; hif.we = 1'b1; hif.wdata = 8'hA5;
        for (int i = 0; i < 64; i++) begin
            hif.addr = 8'(i);
            @(negedge clk);
            chk($sformatf("t2_host_gnt%0d", i), 32'(hif.gnt), 1);
            chk($sformatf("t2_core_gnt%0d", i), 32'(cif.gnt), 0);
            chk($sformatf("t2_stall%0d", i), 32'(core_stall), 1);
            @(posedge clk); #1;
        end
        hif.we = 1'b0; hif.addr = 8'd5; hif.wdata = 8'h00;
        @(negedge clk);
        chk("t2_rd_host_gnt", 32'(hif.gnt), 1);
        chk("t2_rd_host_rvalid_early", 32'(hif.rvalid), 0);
        @(posedge clk); #1;
        hif.req = 1'b0;
        @(negedge clk);
        chk("t2_host_rvalid", 32'(hif.rvalid), 1);
        chk("t2_host_rdata", 32'(hif.rdata), 32'hA5);
        chk("t2_stall_held", 32'(core_stall), 1);
        chk("t2_core_rvalid", 32'(cif.rvalid), 0);

        // Counter saturation on the CW=4 instance
        idle_in();
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        both_read();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("t5_cnt16_%0d", i), 32'(cnt), 32'(i));
            chk($sformatf("t5_cnt4_%0d", i), 32'(cnt4), (i > 15) ? 32'd15 : 32'(i));
            @(posedge clk); #1;
        end
        idle_in();
        @(negedge clk);
        chk("t5_cnt4_hold", 32'(cnt4), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
